// File: rtl/sar_rx_pkg.sv
// Shared types and constants for the SAR ADC result receiver.
package sar_rx_pkg;

    localparam int unsigned HALF_W = 6;
    localparam int unsigned CODE_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        ERR
    } state_t;

    typedef struct packed {
        logic              se;
        logic [CODE_W-1:0] code;
    } entry_t;

    // The ADC drives both half-words inverted; bit 11 is meaningless in single-ended mode.
    function automatic logic [CODE_W-1:0] assemble_code(
        input logic [HALF_W-1:0] up,
        input logic [HALF_W-1:0] lo,
        input logic              se
    );
        return {(se ? 1'b0 : ~up[HALF_W-1]), ~up[HALF_W-2:0], ~lo};
    endfunction

endpackage

// File: rtl/sar_rx_if.sv
// Valid/ready code stream from the receiver to the digital back end.
interface sar_rx_if;
    import sar_rx_pkg::*;

    logic [CODE_W-1:0] code_o;
    logic              code_se_o;
    logic              valid_o;
    logic              ready_i;

    modport master (output code_o, output code_se_o, output valid_o, input ready_i);
    modport slave  (input code_o, input code_se_o, input valid_o, output ready_i);

endinterface

// File: rtl/sar_rx_fifo.sv
// Synchronous code FIFO; pointers carry an extra wrap bit to tell full from empty.
module sar_rx_fifo
    import sar_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_z,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];
    logic        pop_ok;
    logic        push_ok;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign level_o = wr_ptr - rd_ptr;
    assign head_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= data_i;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sar_data_receiver.sv
// Captures the two inverted half-words around each clk_data strobe and queues the rebuilt code.
module sar_data_receiver
    import sar_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MIN_HIGH_CYC = 4,
    parameter int unsigned MAX_HIGH_CYC = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                              clk,
    input  logic                              rst_z,
    input  logic                              clk_data_i,
    input  logic [HALF_W-1:0]                 data_i,
    input  logic                              single_ended_i,
    input  logic                              clr_err_i,
    sar_rx_if.master                          rx,
    output logic                              overflow_o,
    output logic                              frame_err_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
    output logic [CNT_W-1:0]                  frame_cnt_o
);

    localparam int unsigned HC_W = $clog2(MAX_HIGH_CYC + 1);
    localparam logic [HC_W-1:0] MIN_C = HC_W'(MIN_HIGH_CYC);
    localparam logic [HC_W-1:0] MAX_C = HC_W'(MAX_HIGH_CYC);

    state_t            state;
    state_t            state_nx;
    logic              cd_q;
    logic              arm;
    logic              rise;
    logic              fall;
    logic [HALF_W-1:0] up;
    logic              se;
    logic [HC_W-1:0]   hcnt;
    logic [HC_W-1:0]   hcnt_inc;
    logic              push_req;
    logic              err_set;
    logic              ovf_set;
    logic              push_done;
    logic              fifo_full;
    logic              fifo_empty;
    entry_t            push_entry;
    entry_t            head;

    // arm keeps a strobe already high at reset release from looking like a rise.
    assign rise     = clk_data_i & ~cd_q & arm;
    assign fall     = ~clk_data_i & cd_q;
    assign hcnt_inc = hcnt + HC_W'(1);

    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (rise) state_nx = HIGH;
            HIGH: begin
                if (fall) begin
                    state_nx = IDLE;
                end else if (hcnt_inc == MAX_C) begin
                    state_nx = ERR;
                end
            end
            ERR:  if (!clk_data_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        push_req = 1'b0;
        err_set  = 1'b0;
        if (state == HIGH) begin
            if (fall) begin
                if (hcnt < MIN_C) begin
                    err_set = 1'b1;
                end else begin
                    push_req = 1'b1;
                end
            end else if (hcnt_inc == MAX_C) begin
                err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            cd_q <= 1'b0;
            arm  <= 1'b0;
            up   <= '0;
            se   <= 1'b0;
            hcnt <= '0;
        end else begin
            cd_q <= clk_data_i;
            if (!clk_data_i) begin
                arm <= 1'b1;
            end
            if (state == IDLE && rise) begin
                up   <= data_i;
                se   <= single_ended_i;
                hcnt <= HC_W'(1);
            end else if (state == HIGH && clk_data_i) begin
                hcnt <= hcnt_inc;
            end
        end
    end

    assign push_entry.se   = se;
    assign push_entry.code = assemble_code(up, data_i, se);
    assign ovf_set         = push_req & fifo_full & ~rx.ready_i;
    assign push_done       = push_req & ~ovf_set;

    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clr_err_i) begin
                overflow_o <= 1'b0;
            end
            if (err_set) begin
                frame_err_o <= 1'b1;
            end else if (clr_err_i) begin
                frame_err_o <= 1'b0;
            end
            if (push_done) begin
                frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end
        end
    end

    sar_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_z   (rst_z),
        .push_i  (push_req),
        .data_i  (push_entry),
        .pop_i   (rx.ready_i),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign rx.code_o    = head.code;
    assign rx.code_se_o = head.se;
    assign rx.valid_o   = ~fifo_empty;

endmodule

// File: tb/tb_sar_data_receiver.sv
// Scoreboard bench for sar_data_receiver: directed frames with hand-computed codes.
module tb_sar_data_receiver;
    import sar_rx_pkg::*;

    logic        clk      = 1'b0;
    logic        rst_z    = 1'b0;
    logic        clk_data = 1'b0;
    logic [5:0]  data     = '0;
    logic        se_i     = 1'b0;
    logic        clr_err  = 1'b0;
    logic        overflow;
    logic        frame_err;
    logic [2:0]  level;
    logic [15:0] frame_cnt;

    int          checks   = 0;
    int          failures = 0;
    entry_t      exp_q[$];

    sar_rx_if rx ();

    always #5 clk = ~clk;

    sar_data_receiver #(
        .FIFO_DEPTH   (4),
        .MIN_HIGH_CYC (4),
        .MAX_HIGH_CYC (16),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .rst_z          (rst_z),
        .clk_data_i     (clk_data),
        .data_i         (data),
        .single_ended_i (se_i),
        .clr_err_i      (clr_err),
        .rx             (rx),
        .overflow_o     (overflow),
        .frame_err_o    (frame_err),
        .level_o        (level),
        .frame_cnt_o    (frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest outstanding expectation.
    always @(negedge clk) begin
        entry_t e;
        if (rst_z && rx.valid_o && rx.ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_code: got 0x%0h expected none", rx.code_o);
            end else begin
                e = exp_q.pop_front();
                chk("code", {20'd0, rx.code_o}, {20'd0, e.code});
                chk("code_se", {31'd0, rx.code_se_o}, {31'd0, e.se});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [5:0] up, input logic [5:0] lo, input logic se,
                              input int hi, input bit exp_push, input logic [11:0] exp_code,
                              input bit pop_on_fall, input bit clr_on_fall);
        entry_t e;
        data     = up;
        se_i     = se;
        clk_data = 1'b1;
        repeat (hi) tick();
        clk_data = 1'b0;
        data     = lo;
        if (exp_push) begin
            e.se   = se;
            e.code = exp_code;
            exp_q.push_back(e);
        end
        if (pop_on_fall) rx.ready_i = 1'b1;
        if (clr_on_fall) clr_err = 1'b1;
        tick();
        if (pop_on_fall) rx.ready_i = 1'b0;
        clr_err = 1'b0;
        data    = '0;
        se_i    = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        rx.ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rx.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rx.valid_o, 0);
        chk("rst_code", rx.code_o, 0);
        chk("rst_level", level, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        rst_z = 1'b1;
        tick();
        tick();

        rx.ready_i = 1'b1;
        send_frame(6'h16, 6'h23, 1'b0, 6, 1, 12'hA5C, 0, 0);
        chk("diff_cnt", frame_cnt, 1);
        chk("diff_level", level, 0);
        chk("diff_ferr", frame_err, 0);

        send_frame(6'h10, 6'h00, 1'b1, 6, 1, 12'h3FF, 0, 0);
        chk("se_cnt", frame_cnt, 2);

        // Fill with ready low; min-length and max-1-length frames are both legal.
        rx.ready_i = 1'b0;
        send_frame(6'h00, 6'h00, 1'b0, 4,  1, 12'hFFF, 0, 0);
        send_frame(6'h3F, 6'h3F, 1'b0, 15, 1, 12'h000, 0, 0);
        send_frame(6'h2A, 6'h15, 1'b0, 6,  1, 12'h56A, 0, 0);
        send_frame(6'h15, 6'h2A, 1'b0, 6,  1, 12'hA95, 0, 0);
        chk("full_ovf_before", overflow, 0);
        send_frame(6'h01, 6'h02, 1'b0, 6,  0, 12'h000, 0, 0);
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_cnt", frame_cnt, 6);
        chk("ovf_valid", rx.valid_o, 1);
        clear_flags();
        chk("ovf_clr", overflow, 0);

        send_frame(6'h0F, 6'h30, 1'b0, 6, 1, 12'hC0F, 1, 0);
        chk("pp_level", level, 4);
        chk("pp_ovf", overflow, 0);
        chk("pp_cnt", frame_cnt, 7);
        drain();
        chk("drain_level", level, 0);

        send_frame(6'h11, 6'h22, 1'b0, 20, 0, 12'h000, 0, 0);
        chk("tmo_ferr", frame_err, 1);
        chk("tmo_level", level, 0);
        chk("tmo_cnt", frame_cnt, 7);
        clear_flags();
        chk("tmo_clr", frame_err, 0);

        send_frame(6'h11, 6'h22, 1'b0, 2, 0, 12'h000, 0, 0);
        chk("short_ferr", frame_err, 1);
        chk("short_cnt", frame_cnt, 7);
        chk("short_level", level, 0);
        clear_flags();
        chk("short_clr", frame_err, 0);

        send_frame(6'h11, 6'h22, 1'b0, 3, 0, 12'h000, 0, 1);
        chk("clr_vs_err", frame_err, 1);
        clear_flags();
        chk("clr_vs_err_clr", frame_err, 0);

        // Reset mid-frame with one code queued, then release with the strobe still high.
        rx.ready_i = 1'b0;
        send_frame(6'h16, 6'h23, 1'b0, 6, 1, 12'hA5C, 0, 0);
        data     = 6'h05;
        clk_data = 1'b1;
        repeat (3) tick();
        rst_z = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", rx.valid_o, 0);
        chk("mid_rst_code", rx.code_o, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_cnt", frame_cnt, 0);
        tick();
        rst_z = 1'b1;
        repeat (6) tick();
        clk_data = 1'b0;
        repeat (3) tick();
        chk("stale_level", level, 0);
        chk("stale_cnt", frame_cnt, 0);
        chk("stale_ferr", frame_err, 0);
        rx.ready_i = 1'b1;
        send_frame(6'h21, 6'h0C, 1'b0, 6, 1, 12'h7B3, 0, 0);
        chk("recover_cnt", frame_cnt, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
